// File: rtl/pixel_skip_ctrl.sv
// Multi-channel pixel-increment forcer with a lookahead FIFO for raster-ahead found pixels.
// Define PIXEL_SKIP_STATS_EN to implement dropCount/missCount; otherwise both read 0.
module pixel_skip_ctrl #(
    parameter int CHANNELS = 4,
    parameter int COORD_W  = 11,
    parameter int DEPTH    = 8,
    parameter int STAT_W   = 16
) (
    input  logic                          gpuClock,
    input  logic                          gpuReset,
    input  logic                          frameStart,
    input  logic [COORD_W-1:0]            xPixel_pixelCnt,
    input  logic [COORD_W-1:0]            yPixel_pixelCnt,
    input  logic [CHANNELS-1:0]           pixelFound_palette,
    input  logic [CHANNELS*COORD_W-1:0]   xPixel_palette,
    input  logic [CHANNELS*COORD_W-1:0]   yPixel_palette,
    output logic                          pixelIncForce,
    output logic [$clog2(DEPTH):0]        fifoCount,
    output logic                          fifoFull,
    output logic [STAT_W-1:0]             dropCount,
    output logic [STAT_W-1:0]             missCount
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 2 * COORD_W;

    // Keys are {y, x}: unsigned order on the concatenation is raster order.
    logic [ENT_W-1:0] c_key;
    logic [ENT_W-1:0] keys [CHANNELS];
    logic [ENT_W-1:0] mem [DEPTH];
    logic [ENT_W-1:0] head;
    logic [ENT_W-1:0] cand;
    logic [ENT_W-1:0] last_key;
    logic             last_valid;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             direct_hit;
    logic             cand_valid;
    logic             head_hit;
    logic             head_stale;
    logic             pop;
    logic             push_req;
    logic             push;
    logic             full;
    logic             drop_full;

    assign c_key = {yPixel_pixelCnt, xPixel_pixelCnt};

    for (genvar g = 0; g < CHANNELS; g++) begin : g_keys
        assign keys[g] = {yPixel_palette[g*COORD_W +: COORD_W], xPixel_palette[g*COORD_W +: COORD_W]};
    end

    always_comb begin
        direct_hit = 1'b0;
        cand_valid = 1'b0;
        cand       = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (pixelFound_palette[i] && keys[i] == c_key)
                direct_hit = 1'b1;
            if (pixelFound_palette[i] && keys[i] > c_key && !cand_valid) begin
                cand_valid = 1'b1;
                cand       = keys[i];
            end
        end
    end

    assign full       = (count == CNT_W'(DEPTH));
    assign head       = mem[rd_ptr];
    assign head_hit   = !frameStart && count != '0 && head == c_key;
    assign head_stale = !frameStart && count != '0 && head < c_key;
    assign pop        = head_hit | head_stale;
    assign push_req   = !frameStart && cand_valid && !(last_valid && last_key == cand);
    assign push       = push_req && (!full || pop);
    assign drop_full  = push_req && full && !pop;

    always_ff @(posedge gpuClock or posedge gpuReset) begin
        if (gpuReset) begin
            pixelIncForce <= 1'b0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            last_valid    <= 1'b0;
            last_key      <= '0;
        end else begin
            pixelIncForce <= direct_hit | head_hit;
            if (frameStart) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                count      <= '0;
                last_valid <= 1'b0;
            end else begin
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                if (push) begin
                    wr_ptr     <= wr_ptr + PTR_W'(1);
                    last_key   <= cand;
                    last_valid <= 1'b1;
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge gpuClock) begin
        if (push)
            mem[wr_ptr] <= cand;
    end

    assign fifoCount = count;
    assign fifoFull  = full;

`ifdef PIXEL_SKIP_STATS_EN
    localparam int INC_W = $clog2(CHANNELS + 2);

    logic [INC_W-1:0]  n_ahead;
    logic [INC_W-1:0]  n_behind;
    logic [INC_W-1:0]  drop_inc;
    logic [INC_W-1:0]  miss_inc;
    logic [STAT_W-1:0] drop_q;
    logic [STAT_W-1:0] miss_q;

    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a, input logic [INC_W-1:0] b);
        logic [STAT_W:0] s;
        s = {1'b0, a} + (STAT_W+1)'(b);
        return s[STAT_W] ? '1 : s[STAT_W-1:0];
    endfunction

    always_comb begin
        n_ahead  = '0;
        n_behind = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (pixelFound_palette[i] && keys[i] > c_key)
                n_ahead = n_ahead + INC_W'(1);
            if (pixelFound_palette[i] && keys[i] < c_key)
                n_behind = n_behind + INC_W'(1);
        end
        // A flush cycle has no push, so surplus ahead channels are not counted as drops then.
        drop_inc = (frameStart || n_ahead == '0) ? INC_W'(drop_full) : n_ahead - INC_W'(1) + INC_W'(drop_full);
        miss_inc = n_behind + INC_W'(head_stale);
    end

    always_ff @(posedge gpuClock or posedge gpuReset) begin
        if (gpuReset) begin
            drop_q <= '0;
            miss_q <= '0;
        end else begin
            drop_q <= sat_add(drop_q, drop_inc);
            miss_q <= sat_add(miss_q, miss_inc);
        end
    end

    assign dropCount = drop_q;
    assign missCount = miss_q;
`else
    assign dropCount = '0;
    assign missCount = '0;
`endif

endmodule
